// File: rtl/controller_if.sv
// controller_if: opcode/flag inputs and datapath control outputs of the
// mini-MIPS main controller, bundled as one port.
//   master - datapath side: drives op and zero, receives the controls
//   slave  - controller side
interface controller_if;
  logic [5:0] op;
  logic       zero;
  logic       memread;
  logic       memwrite;
  logic       alusrca;
  logic       memtoreg;
  logic       iord;
  logic       pcen;
  logic       regwrite;
  logic       regdst;
  logic [1:0] pcsource;
  logic [1:0] alusrcb;
  logic [1:0] aluop;
  logic [3:0] irwrite;

  modport master (
    output op, zero,
    input  memread, memwrite, alusrca, memtoreg, iord, pcen, regwrite,
           regdst, pcsource, alusrcb, aluop, irwrite
  );

  modport slave (
    input  op, zero,
    output memread, memwrite, alusrca, memtoreg, iord, pcen, regwrite,
           regdst, pcsource, alusrcb, aluop, irwrite
  );
endinterface

// File: rtl/controller.sv
// controller: multicycle main control FSM for the 8-bit mini-MIPS datapath.
// Fetches a 32-bit instruction as four byte reads, decodes the opcode and
// sequences the datapath enables/selects. Outputs are Moore (decoded from the
// state) except pcen, which also folds in the ALU zero flag for BEQ.
// While reset is high every output is forced to 0.
// Optional feature: define CONTROLLER_ADDI_EN to support the ADDI opcode;
// otherwise ADDI is treated as an illegal opcode.
module controller (
  input  logic         clk,
  input  logic         reset,
  controller_if.slave  bus
);

  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef CONTROLLER_ADDI_EN
  localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif

  typedef enum logic [3:0] {
    FETCH1  = 4'd0,
    FETCH2  = 4'd1,
    FETCH3  = 4'd2,
    FETCH4  = 4'd3,
    DECODE  = 4'd4,
    MEMADR  = 4'd5,
    LBRD    = 4'd6,
    LBWR    = 4'd7,
    SBWR    = 4'd8,
    RTYPEEX = 4'd9,
    RTYPEWR = 4'd10,
    BEQEX   = 4'd11,
    JEX     = 4'd12,
    ADDIEX  = 4'd13,
    ADDIWR  = 4'd14
  } state_t;

  state_t     state_reg, state_next;
  logic       pcwrite, branch;
  logic       memread, memwrite, alusrca, memtoreg, iord, regwrite, regdst;
  logic [1:0] pcsource, alusrcb, aluop;
  logic [3:0] irwrite;

  // State register; reset always returns to the first fetch byte.
  always_ff @(posedge clk) begin
    if (reset) state_reg <= FETCH1;
    else       state_reg <= state_next;
  end

  // Next-state logic and Moore output decode; outputs are held low in reset.
  always_comb begin
    state_next = FETCH1;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    memread    = 1'b0;
    memwrite   = 1'b0;
    alusrca    = 1'b0;
    memtoreg   = 1'b0;
    iord       = 1'b0;
    regwrite   = 1'b0;
    regdst     = 1'b0;
    pcsource   = 2'b00;
    alusrcb    = 2'b00;
    aluop      = 2'b00;
    irwrite    = 4'b0000;
    case (state_reg)
      FETCH1: begin
        memread = 1'b1; alusrcb = 2'b01; pcwrite = 1'b1; irwrite = 4'b0001;
        state_next = FETCH2;
      end
      FETCH2: begin
        memread = 1'b1; alusrcb = 2'b01; pcwrite = 1'b1; irwrite = 4'b0010;
        state_next = FETCH3;
      end
      FETCH3: begin
        memread = 1'b1; alusrcb = 2'b01; pcwrite = 1'b1; irwrite = 4'b0100;
        state_next = FETCH4;
      end
      FETCH4: begin
        memread = 1'b1; alusrcb = 2'b01; pcwrite = 1'b1; irwrite = 4'b1000;
        state_next = DECODE;
      end
      DECODE: begin
        // Branch target is precomputed into ALUOut while decoding.
        alusrcb = 2'b11;
        case (bus.op)
          OP_LB, OP_SB: state_next = MEMADR;
          OP_RTYPE:     state_next = RTYPEEX;
          OP_BEQ:       state_next = BEQEX;
          OP_J:         state_next = JEX;
`ifdef CONTROLLER_ADDI_EN
          OP_ADDI:      state_next = ADDIEX;
`endif
          default:      state_next = FETCH1;
        endcase
      end
      MEMADR: begin
        alusrca = 1'b1; alusrcb = 2'b10;
        if (bus.op == OP_LB)      state_next = LBRD;
        else if (bus.op == OP_SB) state_next = SBWR;
        else                      state_next = FETCH1;
      end
      LBRD: begin
        memread = 1'b1; iord = 1'b1;
        state_next = LBWR;
      end
      LBWR: begin
        regwrite = 1'b1; memtoreg = 1'b1;
      end
      SBWR: begin
        memwrite = 1'b1; iord = 1'b1;
      end
      RTYPEEX: begin
        alusrca = 1'b1; aluop = 2'b10;
        state_next = RTYPEWR;
      end
      RTYPEWR: begin
        regdst = 1'b1; regwrite = 1'b1;
      end
      BEQEX: begin
        alusrca = 1'b1; aluop = 2'b01; branch = 1'b1; pcsource = 2'b01;
      end
      JEX: begin
        pcwrite = 1'b1; pcsource = 2'b10;
      end
`ifdef CONTROLLER_ADDI_EN
      ADDIEX: begin
        alusrca = 1'b1; alusrcb = 2'b10;
        state_next = ADDIWR;
      end
      ADDIWR: begin
        regwrite = 1'b1;
      end
`endif
      default: state_next = FETCH1;
    endcase
    if (reset) begin
      pcwrite  = 1'b0;
      branch   = 1'b0;
      memread  = 1'b0;
      memwrite = 1'b0;
      alusrca  = 1'b0;
      memtoreg = 1'b0;
      iord     = 1'b0;
      regwrite = 1'b0;
      regdst   = 1'b0;
      pcsource = 2'b00;
      alusrcb  = 2'b00;
      aluop    = 2'b00;
      irwrite  = 4'b0000;
    end
  end

  assign bus.memread  = memread;
  assign bus.memwrite = memwrite;
  assign bus.alusrca  = alusrca;
  assign bus.memtoreg = memtoreg;
  assign bus.iord     = iord;
  assign bus.regwrite = regwrite;
  assign bus.regdst   = regdst;
  assign bus.pcsource = pcsource;
  assign bus.alusrcb  = alusrcb;
  assign bus.aluop    = aluop;
  assign bus.irwrite  = irwrite;
  assign bus.pcen     = pcwrite | (branch & bus.zero);

endmodule

// File: tb/tb_controller.sv
// tb_controller: randomized scoreboard bench for the controller FSM.
// The stimulus process drives one instruction at a time and pushes the
// expected control vector of every cycle into a queue; the monitor pops and
// compares one vector per cycle on the falling edge.
module tb_controller;

  typedef struct packed {
    logic       memread;
    logic       memwrite;
    logic       alusrca;
    logic       memtoreg;
    logic       iord;
    logic       pcen;
    logic       regwrite;
    logic       regdst;
    logic [1:0] pcsource;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [3:0] irwrite;
  } outs_t;

  typedef struct {
    outs_t      e;
    logic [5:0] op;
    int         step;
  } exp_t;

  localparam logic [5:0] LB    = 6'b100000;
  localparam logic [5:0] SB    = 6'b101000;
  localparam logic [5:0] RTYPE = 6'b000000;
  localparam logic [5:0] BEQ   = 6'b000100;
  localparam logic [5:0] J     = 6'b000010;
  localparam logic [5:0] ADDI  = 6'b001000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  controller_if bus ();

  controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  bit   active = 1'b0;
  bit   done = 1'b0;

  function automatic bit addi_legal();
`ifdef CONTROLLER_ADDI_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // Cycles from FETCH1 entry back to FETCH1 for a given opcode.
  function automatic int instr_len(input logic [5:0] o);
    if (o == LB) return 8;
    if (o == SB || o == RTYPE) return 7;
    if (o == ADDI) return addi_legal() ? 7 : 5;
    if (o == BEQ || o == J) return 6;
    return 5;
  endfunction

  // Expected control outputs for cycle 'step' of an instruction.
  function automatic outs_t exp_out(input logic [5:0] o, input int step, input logic z);
    outs_t e;
    e = '0;
    if (step < 4) begin
      e.memread = 1'b1;
      e.alusrcb = 2'b01;
      e.pcen    = 1'b1;
      e.irwrite = 4'(1 << step);
    end else if (step == 4) begin
      e.alusrcb = 2'b11;
    end else if (o == LB || o == SB) begin
      if (step == 5) begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
      else if (o == LB && step == 6) begin e.memread = 1'b1; e.iord = 1'b1; end
      else if (o == LB && step == 7) begin e.regwrite = 1'b1; e.memtoreg = 1'b1; end
      else if (o == SB && step == 6) begin e.memwrite = 1'b1; e.iord = 1'b1; end
    end else if (o == RTYPE) begin
      if (step == 5) begin e.alusrca = 1'b1; e.aluop = 2'b10; end
      else begin e.regdst = 1'b1; e.regwrite = 1'b1; end
    end else if (o == BEQ) begin
      e.alusrca = 1'b1; e.aluop = 2'b01; e.pcsource = 2'b01; e.pcen = z;
    end else if (o == J) begin
      e.pcen = 1'b1; e.pcsource = 2'b10;
    end else if (o == ADDI && addi_legal()) begin
      if (step == 5) begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
      else e.regwrite = 1'b1;
    end
    return e;
  endfunction

  task automatic push(input outs_t e, input logic [5:0] o, input int step);
    exp_t x;
    x.e = e; x.op = o; x.step = step;
    q.push_back(x);
  endtask

  task automatic do_reset(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      reset = 1'b1;
      bus.op = 6'($urandom);
      bus.zero = 1'($urandom);
      push('0, 6'h3f, -1);
    end
  endtask

  // One instruction; zmode 0/1 fixes zero, 2 randomizes it per cycle.
  // abort_at >= 0 asserts reset for one cycle at that step instead.
  task automatic run_instr(input logic [5:0] o, input int zmode, input int abort_at);
    int n;
    n = instr_len(o);
    for (int s = 0; s < n; s++) begin
      @(posedge clk); #1;
      bus.op   = (s == 4 || s == 5) ? o : 6'($urandom);
      bus.zero = (zmode == 2) ? 1'($urandom) : 1'(zmode);
      if (s == abort_at) begin
        reset = 1'b1;
        push('0, o, -1);
        break;
      end
      reset = 1'b0;
      push(exp_out(o, s, bus.zero), o, s);
    end
  endtask

  // Monitor: one comparison per cycle against the queued expectation.
  initial begin
    outs_t got;
    exp_t  x;
    forever begin
      @(negedge clk);
      if (done) break;
      if (!active) continue;
      got = {bus.memread, bus.memwrite, bus.alusrca, bus.memtoreg, bus.iord,
             bus.pcen, bus.regwrite, bus.regdst, bus.pcsource, bus.alusrcb,
             bus.aluop, bus.irwrite};
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL queue_empty: got outputs %b, required an expected entry", got);
      end else begin
        x = q.pop_front();
        if (got !== x.e) begin
          fails++;
          $display("FAIL ctrl op=%b step=%0d: got %b required %b", x.op, x.step, got, x.e);
        end else begin
          $display("[TB] ok op=%b step=%0d outs=%b", x.op, x.step, got);
        end
      end
    end
  end

  initial begin
    logic [5:0] o;
    int r, ab;
    bus.op = 6'd0;
    bus.zero = 1'b0;
    active = 1'b1;
    do_reset(3);
    run_instr(RTYPE, 2, -1);
    run_instr(LB, 2, -1);
    run_instr(SB, 2, -1);
    run_instr(BEQ, 1, -1);
    run_instr(BEQ, 0, -1);
    run_instr(J, 2, -1);
    run_instr(ADDI, 2, -1);
    run_instr(6'b111111, 2, -1);
    run_instr(LB, 2, 6);
    run_instr(LB, 2, -1);
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 6);
      case (r)
        0: o = LB;
        1: o = SB;
        2: o = RTYPE;
        3: o = BEQ;
        4: o = J;
        5: o = ADDI;
        default: o = 6'($urandom);
      endcase
      ab = ($urandom_range(0, 19) == 0) ? $urandom_range(0, instr_len(o) - 1) : -1;
      run_instr(o, 2, ab);
    end
    @(posedge clk); #1;
    done = 1'b1;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL queue_drain: %0d entries left, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

endmodule
